// File: rtl/tiletest_led_sequencer.sv
// rtl/tiletest_led_sequencer.sv - blinks the error code of one requester at a time, round-robin, with heartbeat when idle
// Build macro TILETEST_LED_STICKY_EN: requests latch until their code has been shown (or clear is pulsed).

module tiletest_led_sequencer #(
  parameter int NREQ      = 4,
  parameter int TICK_LEN  = 4000000,
  parameter int GAP_TICKS = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    heartbeat_in,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [3*NREQ-1:0]       req_code,
  input  logic                    clear,
  output logic                    led,
  output logic [$clog2(NREQ)-1:0] active_req,
  output logic                    busy,
  output logic                    code_done
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int TICK_W = (TICK_LEN > 1) ? $clog2(TICK_LEN) : 1;
  localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_ON,
    S_OFF,
    S_GAP
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [TICK_W-1:0]  tick_q;
  logic [GAP_W-1:0]   gap_q;
  logic [2:0]         blink_q;
  logic [IDX_W-1:0]   last_served;
  logic [NREQ-1:0]    src_valid;
  logic [3*NREQ-1:0]  src_code;
  logic [NREQ-1:0]    pend;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [2:0]         pick_code;
  logic               tick_end;
  logic               gap_last;
  logic               seq_done;
  logic               in_phase;

`ifdef TILETEST_LED_STICKY_EN
  logic [NREQ-1:0]   sticky_flag;
  logic [3*NREQ-1:0] sticky_code;

  // clear beats a same-cycle set; a fresh set beats the completion clear of the same requester
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sticky_flag <= '0;
      sticky_code <= '0;
    end else if (clear) begin
      sticky_flag <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && (req_code[3*i +: 3] != 3'd0)) begin
          sticky_flag[i]         <= 1'b1;
          sticky_code[3*i +: 3]  <= req_code[3*i +: 3];
        end else if (seq_done && (active_req == IDX_W'(i))) begin
          sticky_flag[i] <= 1'b0;
        end
      end
    end
  end

  assign src_valid = sticky_flag;
  assign src_code  = sticky_code;
`else
  logic unused_clear;

  assign unused_clear = clear;
  assign src_valid    = req_valid;
  assign src_code     = req_code;
`endif

  always_comb begin
    pend = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = src_valid[i] && (src_code[3*i +: 3] != 3'd0);
    end
  end

  // Round-robin: first look above last_served, then wrap to the bottom.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_code  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && pend[i] && (i > int'(last_served))) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(i);
        pick_code  = src_code[3*i +: 3];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_found && pend[i] && (i <= int'(last_served))) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(i);
        pick_code  = src_code[3*i +: 3];
      end
    end
  end

  assign in_phase = (state_q == S_ON) || (state_q == S_OFF) || (state_q == S_GAP);
  assign tick_end = in_phase && (tick_q == TICK_W'(TICK_LEN - 1));
  assign gap_last = (gap_q == GAP_W'(GAP_TICKS - 1));
  assign seq_done = (state_q == S_GAP) && tick_end && gap_last;
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (|pend) state_d = S_PICK;
      S_PICK: state_d = pick_found ? S_ON : S_IDLE;
      S_ON:   if (tick_end) state_d = S_OFF;
      S_OFF:  if (tick_end) state_d = (blink_q > 3'd1) ? S_ON : S_GAP;
      S_GAP:  if (seq_done) state_d = S_PICK;
      default: state_d = S_IDLE;
    endcase
  end

  // led is decoded from the next state so it changes on the same edge as the FSM.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_q      <= '0;
      gap_q       <= '0;
      blink_q     <= '0;
      active_req  <= '0;
      last_served <= IDX_W'(NREQ - 1);
      led         <= 1'b0;
      code_done   <= 1'b0;
    end else begin
      code_done <= seq_done;

      if (state_d == S_ON) begin
        led <= 1'b1;
      end else if (state_d == S_IDLE) begin
        led <= heartbeat_in;
      end else begin
        led <= 1'b0;
      end

      if (in_phase && !tick_end) begin
        tick_q <= tick_q + TICK_W'(1);
      end else begin
        tick_q <= '0;
      end

      if ((state_q == S_PICK) && pick_found) begin
        active_req <= pick_idx;
        blink_q    <= pick_code;
        gap_q      <= '0;
      end

      if ((state_q == S_OFF) && tick_end) begin
        blink_q <= blink_q - 3'd1;
      end

      if ((state_q == S_GAP) && tick_end) begin
        gap_q <= gap_last ? '0 : gap_q + GAP_W'(1);
      end

      if (seq_done) begin
        last_served <= active_req;
      end
    end
  end

endmodule

// File: tb/tb_tiletest_led_sequencer.sv
// tb/tb_tiletest_led_sequencer.sv - self-checking bench for tiletest_led_sequencer (NREQ=4, TICK_LEN=4, GAP_TICKS=2)

module tb_tiletest_led_sequencer;

  localparam int NREQ      = 4;
  localparam int TICK_LEN  = 4;
  localparam int GAP_TICKS = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        heartbeat_in;
  logic [3:0]  req_valid;
  logic [11:0] req_code;
  logic        clear;
  logic        led;
  logic [1:0]  active_req;
  logic        busy;
  logic        code_done;

  int checks = 0;
  int errors = 0;

  int last_served;
  bit flag [NREQ];
  int fcode [NREQ];

  tiletest_led_sequencer #(
    .NREQ      (NREQ),
    .TICK_LEN  (TICK_LEN),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .heartbeat_in (heartbeat_in),
    .req_valid    (req_valid),
    .req_code     (req_code),
    .clear        (clear),
    .led          (led),
    .active_req   (active_req),
    .busy         (busy),
    .code_done    (code_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit pending(input int i);
`ifdef TILETEST_LED_STICKY_EN
    return flag[i];
`else
    return req_valid[i] && (req_code[3*i +: 3] != 3'd0);
`endif
  endfunction

  function automatic int code_of(input int i);
`ifdef TILETEST_LED_STICKY_EN
    return fcode[i];
`else
    return int'(req_code[3*i +: 3]);
`endif
  endfunction

  function automatic int next_req();
    int j;
    for (int d = 1; d <= NREQ; d++) begin
      j = (last_served + d) % NREQ;
      if (pending(j)) return j;
    end
    return -1;
  endfunction

  task automatic drive(input logic [3:0] v, input logic [11:0] c);
    req_valid = v;
    req_code  = c;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && (c[3*i +: 3] != 3'd0)) begin
        flag[i]  = 1'b1;
        fcode[i] = int'(c[3*i +: 3]);
      end
    end
  endtask

  task automatic model_reset();
    last_served = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      flag[i]  = 1'b0;
      fcode[i] = 0;
    end
  endtask

  task automatic hb_cycles(input int n);
    logic h;
    for (int i = 0; i < n; i++) begin
      h = 1'($urandom % 2);
      heartbeat_in = h;
      @(negedge sys_clk);
      chk("hb_led", 32'(led), 32'(h));
      chk("hb_busy", 32'(busy), 32'(0));
    end
  endtask

  // Called at the first negedge after ON entry; returns at the negedge after the PICK cycle.
  task automatic play(input int idx, input int code, input int act_k,
                      input logic [3:0] va, input logic [11:0] ca,
                      input logic [3:0] vb, input logic [11:0] cb);
    int len;
    int ph;
    len = (2 * code + GAP_TICKS) * TICK_LEN;
    for (int k = 0; k < len; k++) begin
      ph = k / TICK_LEN;
      chk("seq_led", 32'(led), 32'((ph < 2 * code) && (ph % 2 == 0)));
      chk("seq_active_req", 32'(active_req), 32'(idx));
      chk("seq_busy", 32'(busy), 32'(1));
      chk("seq_code_done_early", 32'(code_done), 32'(0));
      if (k == act_k) drive(va, ca);
      if (k == act_k + 1) drive(vb, cb);
      heartbeat_in = 1'($urandom % 2);
      @(negedge sys_clk);
    end
    chk("code_done_pulse", 32'(code_done), 32'(1));
    chk("pick_led", 32'(led), 32'(0));
    last_served = idx;
    flag[idx]   = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic kick(input logic [3:0] v, input logic [11:0] c);
    drive(v, c);
    @(negedge sys_clk);
    chk("pick_busy", 32'(busy), 32'(1));
    chk("pick_led_low", 32'(led), 32'(0));
    @(negedge sys_clk);
  endtask

  task automatic run_all();
    int n;
    logic [3:0] v;
    for (int s = 0; s < 8; s++) begin
      n = next_req();
      if (n < 0) break;
      v    = req_valid;
      v[n] = 1'b0;
      play(n, code_of(n), 1, v, req_code, v, req_code);
    end
    chk("idle_after_run", 32'(busy), 32'(0));
  endtask

  initial begin
    int c;
    int c1;
    int c3;
    int j;
    logic [3:0]  rv;
    logic [11:0] rc;

    sys_rst_n    = 1'b0;
    heartbeat_in = 1'b0;
    clear        = 1'b0;
    req_valid    = '0;
    req_code     = '0;
    model_reset();

    repeat (2) @(negedge sys_clk);
    chk("rst_led", 32'(led), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_code_done", 32'(code_done), 32'(0));
    chk("rst_active_req", 32'(active_req), 32'(0));
    sys_rst_n = 1'b1;

    hb_cycles(16);

    // Single requester, code 3: 32 cycles ON entry to code_done, then idle.
    kick(4'b0001, 12'h003);
    run_all();
    hb_cycles(4);

    // Two requesters: round-robin from last_served=0 gives req1 then req3.
    c1 = $urandom_range(1, 7);
    c3 = $urandom_range(1, 7);
    kick(4'b1010, 12'(c1 << 3) | 12'(c3 << 9));
    run_all();
    chk("rr_last_is_3", 32'(last_served), 32'(3));

    // Valid with code 0 is ignored.
    drive(4'b0100, 12'h000);
    hb_cycles(10);
    drive(4'b0000, 12'h000);

    // req2 pulsed for one cycle during req0's sequence.
    c = $urandom_range(1, 7);
    kick(4'b0001, 12'(c));
    play(0, c, 5, 4'b0100, 12'h080, 4'b0000, 12'h000);
    run_all();
    hb_cycles(4);

    // Asynchronous reset in the second ON phase.
    c = $urandom_range(2, 7);
    kick(4'b0010, 12'(c << 3));
    repeat (2 * TICK_LEN + 1) @(negedge sys_clk);
    chk("second_on_led", 32'(led), 32'(1));
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_active_req", 32'(active_req), 32'(0));
    drive(4'b0000, 12'h000);
    model_reset();
    repeat (3) begin
      @(negedge sys_clk);
      chk("rst_no_code_done", 32'(code_done), 32'(0));
    end
    sys_rst_n = 1'b1;
    repeat (3) begin
      @(negedge sys_clk);
      chk("post_rst_idle", 32'(busy), 32'(0));
      chk("post_rst_no_done", 32'(code_done), 32'(0));
    end

    // Random request mixes, played out round-robin against the model.
    for (int r = 0; r < 4; r++) begin
      rv = 4'($urandom_range(0, 15));
      rc = 12'($urandom);
      j  = $urandom_range(0, NREQ - 1);
      rv[j] = 1'b1;
      if (rc[3*j +: 3] == 3'd0) rc[3*j +: 3] = 3'd5;
      kick(rv, rc);
      run_all();
      drive(4'b0000, 12'h000);
      hb_cycles(3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
